multi_cycle_ctr: RTL

MULTI_CYCLE_CTR -- requirements
Module: multi_cycle_ctr

---
 rtl/mips_pkg.sv | 40 ++++
 rtl/multi_cycle_ctr_op_class.sv | 24 ++
 rtl/multi_cycle_ctr.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/mips_pkg.sv
// Shared types and constants for the multi-cycle MIPS control unit.
package mips_pkg;

    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_FETCH  = 4'd1,
        S_DECODE = 4'd2,
        S_MEMADR = 4'd3,
        S_MEMRD  = 4'd4,
        S_MEMWB  = 4'd5,
        S_MEMWR  = 4'd6,
        S_EXEC   = 4'd7,
        S_ALUWB  = 4'd8,
        S_BRANCH = 4'd9,
        S_JUMP   = 4'd10,
        S_ADDIEX = 4'd11,
        S_ADDIWB = 4'd12
    } state_e;

    typedef enum logic [2:0] {
        CLS_RTYPE   = 3'd0,
        CLS_MEM     = 3'd1,
        CLS_BEQ     = 3'd2,
        CLS_J       = 3'd3,
        CLS_ADDI    = 3'd4,
        CLS_ILLEGAL = 3'd5
    } op_class_e;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;

endpackage

// File: rtl/multi_cycle_ctr_op_class.sv
// Combinational opcode classifier used by the DECODE state.
module op_class
    import mips_pkg::*;
#(
    parameter int ADDI_EN = 1
) (
    input  logic [5:0] opcode_i,
    output op_class_e  class_o
);

    // Map an opcode to its instruction class; addi is illegal when disabled.
    always_comb begin
        class_o = CLS_ILLEGAL;
        case (opcode_i)
            OP_RTYPE:     class_o = CLS_RTYPE;
            OP_LW, OP_SW: class_o = CLS_MEM;
            OP_BEQ:       class_o = CLS_BEQ;
            OP_J:         class_o = CLS_J;
            OP_ADDI:      class_o = (ADDI_EN != 0) ? CLS_ADDI : CLS_ILLEGAL;
            default:      class_o = CLS_ILLEGAL;
        endcase
    end

endmodule

// File: rtl/multi_cycle_ctr.sv
// Multi-cycle MIPS control FSM with optional memory handshake.
//
// state  | meaning
// IDLE   | post-reset, all outputs low
// FETCH  | read instruction, PC+4 when memory ready
// DECODE | latch opcode, compute branch target, dispatch
// MEMADR | compute load/store address
// MEMRD  | load data read
// MEMWB  | load write-back
// MEMWR  | store data write
// EXEC   | R-type ALU operation
// ALUWB  | R-type write-back
// BRANCH | beq compare and conditional PC update
// JUMP   | unconditional jump
// ADDIEX | addi ALU operation
// ADDIWB | addi write-back
module multi_cycle_ctr
    import mips_pkg::*;
#(
    parameter int MEM_HANDSHAKE = 1,
    parameter int ADDI_EN       = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] OpCode,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       IorD,
    output logic       IRWrite,
    output logic       PCWrite,
    output logic       Branch,
    output logic       RegDst,
    output logic       RegWr,
    output logic       MemWr,
    output logic       Mem2Reg,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ALUOp,
    output logic [1:0] PCSrc,
    output logic       illegal_op,
    output logic       instr_done
);

    state_e     state_q, state_d;
    logic [5:0] op_q, op_d;
    op_class_e  op_cls;
    logic       rdy;

    assign rdy = (MEM_HANDSHAKE != 0) ? mem_ready : 1'b1;

    op_class #(.ADDI_EN(ADDI_EN)) u_op_class (
        .opcode_i (OpCode),
        .class_o  (op_cls)
    );

    // State and latched opcode registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            op_q    <= 6'b000000;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
        end
    end

    // Next-state logic; OpCode is only looked at in DECODE.
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        case (state_q)
            S_IDLE:   state_d = S_FETCH;
            S_FETCH:  if (rdy) state_d = S_DECODE;
            S_DECODE: begin
                op_d = OpCode;
                case (op_cls)
                    CLS_RTYPE: state_d = S_EXEC;
                    CLS_MEM:   state_d = S_MEMADR;
                    CLS_BEQ:   state_d = S_BRANCH;
                    CLS_J:     state_d = S_JUMP;
                    CLS_ADDI:  state_d = S_ADDIEX;
                    default:   state_d = S_FETCH;
                endcase
            end
            S_MEMADR: state_d = (op_q == OP_LW) ? S_MEMRD : S_MEMWR;
            S_MEMRD:  if (rdy) state_d = S_MEMWB;
            S_MEMWB:  state_d = S_FETCH;
            S_MEMWR:  if (rdy) state_d = S_FETCH;
            S_EXEC:   state_d = S_ALUWB;
            S_ALUWB:  state_d = S_FETCH;
            S_BRANCH: state_d = S_FETCH;
            S_JUMP:   state_d = S_FETCH;
            S_ADDIEX: state_d = S_ADDIWB;
            S_ADDIWB: state_d = S_FETCH;
            default:  state_d = S_IDLE;
        endcase
    end

    // Moore-style output decode, with rdy qualifying the handshake states.
    always_comb begin
        mem_req    = 1'b0;
        IorD       = 1'b0;
        IRWrite    = 1'b0;
        PCWrite    = 1'b0;
        Branch     = 1'b0;
        RegDst     = 1'b0;
        RegWr      = 1'b0;
        MemWr      = 1'b0;
        Mem2Reg    = 1'b0;
        ALUSrcA    = 1'b0;
        ALUSrcB    = 2'b00;
        ALUOp      = ALU_ADD;
        PCSrc      = 2'b00;
        illegal_op = 1'b0;
        instr_done = 1'b0;
        case (state_q)
            S_FETCH: begin
                mem_req = 1'b1;
                ALUSrcB = 2'b01;
                IRWrite = rdy;
                PCWrite = rdy;
            end
            S_DECODE: begin
                ALUSrcB    = 2'b11;
                illegal_op = (op_cls == CLS_ILLEGAL);
            end
            S_MEMADR: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
            end
            S_MEMRD: begin
                mem_req = 1'b1;
                IorD    = 1'b1;
            end
            S_MEMWB: begin
                Mem2Reg    = 1'b1;
                RegWr      = 1'b1;
                instr_done = 1'b1;
            end
            S_MEMWR: begin
                mem_req    = 1'b1;
                IorD       = 1'b1;
                MemWr      = 1'b1;
                instr_done = rdy;
            end
            S_EXEC: begin
                ALUSrcA = 1'b1;
                ALUOp   = ALU_FUNCT;
            end
            S_ALUWB: begin
                RegDst     = 1'b1;
                RegWr      = 1'b1;
                instr_done = 1'b1;
            end
            S_BRANCH: begin
                ALUSrcA    = 1'b1;
                ALUOp      = ALU_SUB;
                PCSrc      = 2'b01;
                Branch     = 1'b1;
                instr_done = 1'b1;
            end
            S_JUMP: begin
                PCSrc      = 2'b10;
                PCWrite    = 1'b1;
                instr_done = 1'b1;
            end
            S_ADDIEX: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
            end
            S_ADDIWB: begin
                RegWr      = 1'b1;
                instr_done = 1'b1;
            end
            default: ;
        endcase
    end

endmodule
